// File: rtl/bmp_col_packer_pkg.sv
// Shared definitions for the bitmap column packer and the comparator top.
package bmp_col_packer_pkg;

  // Default geometry: 64 rows per column, 24 columns per bitmap (1536 bits).
  localparam int unsigned COLW_DEF  = 64;
  localparam int unsigned NCOLS_DEF = 24;

  // Width of the comparator result word.
  localparam int unsigned RESW = 13;

  // Packer frame states.
  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWrite,
    StWaitDone
  } bmp_state_e;

endpackage

// File: rtl/bmp_col_packer.sv
// Packs a stream of COLW-bit columns into a COLW*NCOLS bitmap, strobes it into
// the comparator once full, then waits for the comparator and captures its result.
module bmp_col_packer
  import bmp_col_packer_pkg::*;
#(
  parameter int unsigned COLW  = COLW_DEF,
  parameter int unsigned NCOLS = NCOLS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COLW-1:0]       colin_i,
  input  logic                  colvalid_i,
  output logic                  colready_o,
  input  logic                  clear_i,
  output logic [COLW*NCOLS-1:0] bitmap_o,
  output logic                  wren_o,
  input  logic                  cmpdone_i,
  input  logic [RESW-1:0]       cmpresult_i,
  output logic [RESW-1:0]       result_o,
  output logic                  result_valid_o,
  output logic                  busy_o
);

  localparam int unsigned IdxW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCOLS - 1);

  bmp_state_e             state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [COLW*NCOLS-1:0]  bitmap_q, bitmap_d;
  logic [RESW-1:0]        result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   accept;

  // Handshake and strobes are decoded from the state register only.
  always_comb begin
    colready_o = (state_q == StIdle) || (state_q == StFill);
    wren_o     = (state_q == StWrite);
    busy_o     = (state_q == StWrite) || (state_q == StWaitDone);
    accept     = colvalid_i && colready_o && !clear_i;
  end

  // Next-state: column placement, frame sequencing and result capture.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    bitmap_d       = bitmap_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    unique case (state_q)
      StIdle, StFill: begin
        if (clear_i) begin
          // Flush restarts the frame but keeps stale bitmap contents.
          state_d = StIdle;
          idx_d   = '0;
        end else if (accept) begin
          bitmap_d[int'(idx_q)*COLW +: COLW] = colin_i;
          if (idx_q == LastIdx) begin
            state_d = StWrite;
            idx_d   = '0;
          end else begin
            state_d = StFill;
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end
      StWrite: begin
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (cmpdone_i) begin
          state_d        = StIdle;
          idx_d          = '0;
          result_d       = cmpresult_i;
          result_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // State registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      bitmap_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      bitmap_q       <= bitmap_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bitmap_o       = bitmap_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;

endmodule

// File: tb/tb_bmp_col_packer.sv
// Self-checking bench for bmp_col_packer: a per-cycle vector table, directed
// frame sequences and a randomized two-frame run against a column-list model.
module tb_bmp_col_packer;
  import bmp_col_packer_pkg::*;

  localparam int unsigned COLW  = 64;
  localparam int unsigned NCOLS = 24;
  localparam int unsigned BW    = COLW * NCOLS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [COLW-1:0] colin;
  logic            colvalid;
  logic            colready;
  logic            clear;
  logic [BW-1:0]   bitmap;
  logic            wren;
  logic            cmpdone;
  logic [RESW-1:0] cmpresult;
  logic [RESW-1:0] result;
  logic            result_valid;
  logic            busy;

  always #5 clk = ~clk;

  bmp_col_packer #(
    .COLW (COLW),
    .NCOLS(NCOLS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .colin_i       (colin),
    .colvalid_i    (colvalid),
    .colready_o    (colready),
    .clear_i       (clear),
    .bitmap_o      (bitmap),
    .wren_o        (wren),
    .cmpdone_i     (cmpdone),
    .cmpresult_i   (cmpresult),
    .result_o      (result),
    .result_valid_o(result_valid),
    .busy_o        (busy)
  );

  // Reference: expected content of every bitmap slot, and the number of
  // columns accepted so far in the current frame.
  logic [COLW-1:0] mbm [NCOLS];
  int              m_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Whole-bitmap comparison, reported as one check at the first bad slot.
  task automatic check_bm(input string name);
    int bad;
    bad = -1;
    for (int k = NCOLS - 1; k >= 0; k--) begin
      if (bitmap[k*COLW +: COLW] !== mbm[k]) bad = k;
    end
    n_checks++;
    if (bad < 0) n_pass++;
    else $display("FAIL %s: slot %0d got %h, expected %h", name, bad,
                  bitmap[bad*COLW +: COLW], mbm[bad]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    colvalid  = 1'b0;
    colin     = '0;
    clear     = 1'b0;
    cmpdone   = 1'b0;
    cmpresult = '0;
  endtask

  task automatic model_zero();
    for (int k = 0; k < NCOLS; k++) mbm[k] = '0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle presenting a column while the packer is expected to accept it.
  task automatic push(input logic [COLW-1:0] d, input string name);
    check({name, " colready"}, colready, 1'b1);
    colvalid = 1'b1;
    colin    = d;
    tick();
    colvalid = 1'b0;
    mbm[m_cnt] = d;
    m_cnt++;
    check({name, " wren"}, wren, (m_cnt == NCOLS));
    if (m_cnt == NCOLS) m_cnt = 0;
  endtask

  // Finish a frame already in WAIT_DONE with the given comparator result.
  task automatic finish_frame(input logic [RESW-1:0] r, input string name);
    cmpdone   = 1'b1;
    cmpresult = r;
    tick();
    cmpdone = 1'b0;
    check({name, " result_valid"}, result_valid, 1'b1);
    check({name, " result"}, result, r);
    check({name, " colready"}, colready, 1'b1);
  endtask

  typedef struct {
    logic            v;
    logic [COLW-1:0] col;
    logic            clr;
    logic            done;
    logic            ready;
    logic            busy;
    logic            rv;
    logic [COLW-1:0] s0;
    logic [COLW-1:0] s1;
  } vec_t;

  vec_t tv [6];

  initial begin
    // Cycle-by-cycle table after reset: cmpdone ignored in IDLE/FILL, clear
    // beats colvalid, clear keeps bitmap contents and restarts at slot 0.
    tv[0] = '{v:1'b0, col:64'h0,  clr:1'b0, done:1'b1, ready:1'b1, busy:1'b0, rv:1'b0,
              s0:64'h0,  s1:64'h0};
    tv[1] = '{v:1'b1, col:64'hAA, clr:1'b1, done:1'b0, ready:1'b1, busy:1'b0, rv:1'b0,
              s0:64'h0,  s1:64'h0};
    tv[2] = '{v:1'b1, col:64'h11, clr:1'b0, done:1'b0, ready:1'b1, busy:1'b0, rv:1'b0,
              s0:64'h11, s1:64'h0};
    tv[3] = '{v:1'b1, col:64'h22, clr:1'b0, done:1'b1, ready:1'b1, busy:1'b0, rv:1'b0,
              s0:64'h11, s1:64'h22};
    tv[4] = '{v:1'b0, col:64'h0,  clr:1'b1, done:1'b0, ready:1'b1, busy:1'b0, rv:1'b0,
              s0:64'h11, s1:64'h22};
    tv[5] = '{v:1'b1, col:64'h33, clr:1'b0, done:1'b0, ready:1'b1, busy:1'b0, rv:1'b0,
              s0:64'h33, s1:64'h22};

    do_reset();
    #1;
    check("reset colready", colready, 1'b1);
    check("reset wren", wren, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset result_valid", result_valid, 1'b0);
    check("reset result", result, '0);
    check_bm("reset bitmap");

    for (int i = 0; i < 6; i++) begin
      colvalid = tv[i].v;
      colin    = tv[i].col;
      clear    = tv[i].clr;
      cmpdone  = tv[i].done;
      tick();
      check($sformatf("vec%0d colready", i), colready, tv[i].ready);
      check($sformatf("vec%0d busy", i), busy, tv[i].busy);
      check($sformatf("vec%0d result_valid", i), result_valid, tv[i].rv);
      check($sformatf("vec%0d slot0", i), bitmap[COLW-1:0], tv[i].s0);
      check($sformatf("vec%0d slot1", i), bitmap[2*COLW-1:COLW], tv[i].s1);
    end
    idle_inputs();

    // Full frame with colvalid held high, columns k+1.
    do_reset();
    for (int k = 0; k < NCOLS; k++) push(64'(k + 1), $sformatf("frameA col%0d", k));
    check("frameA write busy", busy, 1'b1);
    check("frameA write colready", colready, 1'b0);
    check("frameA slot0", bitmap[63:0], 64'd1);
    check("frameA slot23", bitmap[1535:1472], 64'd24);
    check_bm("frameA bitmap");
    // cmpdone during WRITE is ignored; colvalid is refused.
    colvalid  = 1'b1;
    colin     = 64'hDEAD;
    cmpdone   = 1'b1;
    cmpresult = 13'h1FFF;
    tick();
    check("frameA wait wren", wren, 1'b0);
    check("frameA wait busy", busy, 1'b1);
    check("frameA done-in-write rv", result_valid, 1'b0);
    check("frameA done-in-write result", result, '0);
    check("frameA wait colready", colready, 1'b0);
    check_bm("frameA wait bitmap");
    // clear in WAIT_DONE is ignored.
    cmpdone = 1'b0;
    clear   = 1'b1;
    tick();
    clear    = 1'b0;
    colvalid = 1'b0;
    check("frameA clear-in-wait busy", busy, 1'b1);
    check_bm("frameA clear-in-wait bitmap");
    finish_frame(13'h0ABC, "frameA");
    check("frameA idle busy", busy, 1'b0);
    tick();
    check("frameA rv one cycle", result_valid, 1'b0);
    check("frameA result hold", result, 13'h0ABC);

    // 10 columns, clear with colvalid, then a full fresh frame.
    for (int k = 0; k < 10; k++) push(64'h100 + 64'(k), $sformatf("frameB pre%0d", k));
    colvalid = 1'b1;
    colin    = 64'hBAD;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    colvalid = 1'b0;
    m_cnt    = 0;
    check("frameB clear wren", wren, 1'b0);
    check_bm("frameB clear bitmap kept");
    for (int k = 0; k < NCOLS; k++) push(64'h200 + 64'(k), $sformatf("frameB col%0d", k));
    check("frameB slot0", bitmap[63:0], 64'h200);
    check_bm("frameB bitmap");
    tick();
    finish_frame(13'h0123, "frameB");

    // Reset pulsed mid-frame at column 12.
    for (int k = 0; k < 12; k++) push(64'h300 + 64'(k), $sformatf("frameC pre%0d", k));
    #2;
    rst_n = 1'b0;
    #1;
    model_zero();
    check_bm("frameC reset bitmap");
    check("frameC reset colready", colready, 1'b1);
    check("frameC reset wren", wren, 1'b0);
    check("frameC reset result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NCOLS; k++) push(64'h400 + 64'(k), $sformatf("frameC col%0d", k));
    check_bm("frameC bitmap");
    tick();
    finish_frame(13'h0777, "frameC");

    // Two back-to-back frames with random gaps, occasional clears and
    // random comparator latency.
    for (int f = 0; f < 2; f++) begin
      int guard;
      int wrens;
      logic [RESW-1:0] r;
      guard = 0;
      wrens = 0;
      while (wrens == 0 && guard < 2000) begin
        logic v;
        logic c;
        logic [COLW-1:0] d;
        guard++;
        v = ($urandom_range(0, 2) != 0);
        c = (f == 0) && ($urandom_range(0, 15) == 0);
        d = {$urandom, $urandom};
        if (colready !== 1'b1) begin
          check($sformatf("rand f%0d colready", f), colready, 1'b1);
        end
        colvalid = v;
        colin    = d;
        clear    = c;
        tick();
        if (c) m_cnt = 0;
        else if (v) begin
          mbm[m_cnt] = d;
          m_cnt++;
        end
        check($sformatf("rand f%0d wren", f), wren, (m_cnt == NCOLS));
        if (wren === 1'b1) wrens++;
      end
      idle_inputs();
      check($sformatf("rand f%0d frame seen", f), wrens, 1);
      m_cnt = 0;
      check_bm($sformatf("rand f%0d bitmap", f));
      repeat ($urandom_range(1, 4)) begin
        colvalid = 1'b1;
        colin    = {$urandom, $urandom};
        tick();
        check($sformatf("rand f%0d wait wren", f), wren, 1'b0);
        check($sformatf("rand f%0d wait rv", f), result_valid, 1'b0);
      end
      colvalid = 1'b0;
      check_bm($sformatf("rand f%0d wait bitmap", f));
      r = RESW'($urandom);
      finish_frame(r, $sformatf("rand f%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
